// File: rtl/dram_gate_pkg.sv
// Shared types and constants for the DRAM AXI calibration gate.
// Holds the default AXI request/response structs, state encodings and response codes.
package dram_gate_pkg;

  localparam int unsigned AxiIdWidth          = 4;
  localparam int unsigned AxiAddrWidth        = 32;
  localparam int unsigned AxiDataWidth        = 32;
  localparam int unsigned AxiLenWidth         = 8;
  localparam int unsigned DefaultCalibTimeout = 2 ** 20;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  typedef enum logic [2:0] {
    WAIT_CALIB = 3'd0,
    ACTIVE     = 3'd1,
    DRAIN      = 3'd2,
    ISOLATED   = 3'd3,
    ERROR      = 3'd4
  } dram_gate_state_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WDATA = 2'd1,
    BRESP = 2'd2,
    RDATA = 2'd3
  } err_slv_state_e;

  typedef struct packed {
    logic [AxiIdWidth-1:0]     aw_id;
    logic [AxiAddrWidth-1:0]   aw_addr;
    logic [AxiLenWidth-1:0]    aw_len;
    logic                      aw_valid;
    logic [AxiDataWidth-1:0]   w_data;
    logic [AxiDataWidth/8-1:0] w_strb;
    logic                      w_last;
    logic                      w_valid;
    logic                      b_ready;
    logic [AxiIdWidth-1:0]     ar_id;
    logic [AxiAddrWidth-1:0]   ar_addr;
    logic [AxiLenWidth-1:0]    ar_len;
    logic                      ar_valid;
    logic                      r_ready;
  } dram_axi_req_t;

  typedef struct packed {
    logic                    aw_ready;
    logic                    w_ready;
    logic [AxiIdWidth-1:0]   b_id;
    logic [1:0]              b_resp;
    logic                    b_valid;
    logic                    ar_ready;
    logic [AxiIdWidth-1:0]   r_id;
    logic [AxiDataWidth-1:0] r_data;
    logic [1:0]              r_resp;
    logic                    r_last;
    logic                    r_valid;
  } dram_axi_resp_t;

endpackage

// File: rtl/dram_gate_err_slv.sv
// SLVERR responder used while the gate is in ERROR: serves one burst at a time,
// reads take priority over writes arriving in the same cycle.
module dram_gate_err_slv
  import dram_gate_pkg::*;
#(
  parameter int unsigned IdWidth    = AxiIdWidth,
  parameter type         axi_req_t  = dram_axi_req_t,
  parameter type         axi_resp_t = dram_axi_resp_t
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      en,
  input  axi_req_t  req,
  output axi_resp_t rsp,
  output logic      busy
);

  err_slv_state_e         state, state_next;
  logic [IdWidth-1:0]     id, id_next;
  logic [AxiLenWidth-1:0] beats, beats_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      id    <= '0;
      beats <= '0;
    end else begin
      state <= state_next;
      id    <= id_next;
      beats <= beats_next;
    end
  end

  always_comb begin
    state_next = state;
    id_next    = id;
    beats_next = beats;
    rsp        = '0;
    case (state)
      IDLE: begin
        if (en) begin
          rsp.ar_ready = 1'b1;
          rsp.aw_ready = ~req.ar_valid;
          if (req.ar_valid) begin
            state_next = RDATA;
            id_next    = req.ar_id;
            beats_next = req.ar_len;
          end else if (req.aw_valid) begin
            state_next = WDATA;
            id_next    = req.aw_id;
          end
        end
      end
      WDATA: begin
        rsp.w_ready = 1'b1;
        if (req.w_valid && req.w_last) state_next = BRESP;
      end
      BRESP: begin
        rsp.b_valid = 1'b1;
        rsp.b_id    = id;
        rsp.b_resp  = RespSlvErr;
        if (req.b_ready) state_next = IDLE;
      end
      RDATA: begin
        rsp.r_valid = 1'b1;
        rsp.r_id    = id;
        rsp.r_resp  = RespSlvErr;
        rsp.r_last  = (beats == '0);
        if (req.r_ready) begin
          if (beats == '0) state_next = IDLE;
          else beats_next = beats - 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: rtl/dram_axi_calib_gate.sv
// Holds AXI traffic off until DRAM calibration completes, tracks outstanding bursts, drains/isolates on request.
// Build option DRAM_GATE_ERR_RESP_EN: answer upstream with SLVERR while in ERROR instead of stalling.
module dram_axi_calib_gate
  import dram_gate_pkg::*;
#(
  parameter int unsigned IdWidth      = AxiIdWidth,
  parameter int unsigned MaxTxns      = 16,
  parameter int unsigned CalibTimeout = DefaultCalibTimeout,
  parameter type         axi_req_t    = dram_axi_req_t,
  parameter type         axi_resp_t   = dram_axi_resp_t
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       calib_done_i,
  input  logic       isolate_i,
  output logic       isolated_o,
  output logic [2:0] state_o,
  output logic       calib_timeout_o,
  input  axi_req_t   slv_req_i,
  output axi_resp_t  slv_rsp_o,
  output axi_req_t   mst_req_o,
  input  axi_resp_t  mst_rsp_i
);

  localparam int unsigned              CntWidth   = $clog2(MaxTxns + 1);
  localparam int unsigned              TimerWidth = $clog2(CalibTimeout) + 1;
  localparam logic [CntWidth-1:0]      CntMax     = CntWidth'(MaxTxns);
  localparam logic [TimerWidth-1:0]    TimerLast  = TimerWidth'(CalibTimeout - 1);

  if (MaxTxns < 1 || CalibTimeout < 1 || IdWidth < 1) begin : g_bad_params
    $error("dram_axi_calib_gate: MaxTxns, CalibTimeout and IdWidth must be at least 1");
  end

  dram_gate_state_e      state, state_next;
  logic [CntWidth-1:0]   wr_cnt, rd_cnt, wp_cnt;
  logic [TimerWidth-1:0] timer;
  logic                  calib_timeout;
  logic                  flow, aw_ok, ar_ok, w_ok, drained, err_busy;
  logic                  aw_hs, ar_hs, w_last_hs, b_hs, r_last_hs;

  assign flow    = (state == ACTIVE) || (state == DRAIN);
  assign aw_ok   = (state == ACTIVE) && (wr_cnt < CntMax);
  assign ar_ok   = (state == ACTIVE) && (rd_cnt < CntMax);
  assign w_ok    = flow && (wp_cnt != '0);
  assign drained = (wr_cnt == '0) && (rd_cnt == '0) && (wp_cnt == '0);

`ifdef DRAM_GATE_ERR_RESP_EN
  axi_resp_t err_rsp;

  dram_gate_err_slv #(
    .IdWidth    (IdWidth),
    .axi_req_t  (axi_req_t),
    .axi_resp_t (axi_resp_t)
  ) u_err_slv (
    .clk  (clk_i),
    .rst  (rst_i),
    .en   ((state == ERROR) && !calib_done_i),
    .req  (slv_req_i),
    .rsp  (err_rsp),
    .busy (err_busy)
  );
`else
  assign err_busy = 1'b0;
`endif

  always_comb begin
    mst_req_o          = slv_req_i;
    slv_rsp_o          = mst_rsp_i;
    mst_req_o.aw_valid = slv_req_i.aw_valid & aw_ok;
    mst_req_o.ar_valid = slv_req_i.ar_valid & ar_ok;
    mst_req_o.w_valid  = slv_req_i.w_valid & w_ok;
    mst_req_o.b_ready  = slv_req_i.b_ready & flow;
    mst_req_o.r_ready  = slv_req_i.r_ready & flow;
    slv_rsp_o.aw_ready = mst_rsp_i.aw_ready & aw_ok;
    slv_rsp_o.ar_ready = mst_rsp_i.ar_ready & ar_ok;
    slv_rsp_o.w_ready  = mst_rsp_i.w_ready & w_ok;
    slv_rsp_o.b_valid  = mst_rsp_i.b_valid & flow;
    slv_rsp_o.r_valid  = mst_rsp_i.r_valid & flow;
`ifdef DRAM_GATE_ERR_RESP_EN
    if (state == ERROR) slv_rsp_o = err_rsp;
`endif
  end

  assign aw_hs     = mst_req_o.aw_valid & mst_rsp_i.aw_ready;
  assign ar_hs     = mst_req_o.ar_valid & mst_rsp_i.ar_ready;
  assign w_last_hs = mst_req_o.w_valid & mst_rsp_i.w_ready & slv_req_i.w_last;
  assign b_hs      = mst_rsp_i.b_valid & mst_req_o.b_ready;
  assign r_last_hs = mst_rsp_i.r_valid & mst_req_o.r_ready & mst_rsp_i.r_last;

  always_comb begin
    state_next = state;
    case (state)
      WAIT_CALIB: begin
        if (isolate_i)             state_next = ISOLATED;
        else if (calib_done_i)     state_next = ACTIVE;
        else if (timer == TimerLast) state_next = ERROR;
      end
      ACTIVE: if (isolate_i || !calib_done_i) state_next = DRAIN;
      DRAIN: begin
        if (drained) begin
          if (isolate_i)          state_next = ISOLATED;
          else if (!calib_done_i) state_next = WAIT_CALIB;
          else                    state_next = ACTIVE;
        end
      end
      ISOLATED: if (!isolate_i) state_next = WAIT_CALIB;
      ERROR:    if (calib_done_i && !err_busy) state_next = ACTIVE;
      default:  state_next = WAIT_CALIB;
    endcase
  end

  // Timer only runs while staying in WAIT_CALIB, so every re-entry starts from zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= WAIT_CALIB;
      timer         <= '0;
      calib_timeout <= 1'b0;
      wr_cnt        <= '0;
      rd_cnt        <= '0;
      wp_cnt        <= '0;
    end else begin
      state  <= state_next;
      timer  <= (state == WAIT_CALIB && state_next == WAIT_CALIB) ? timer + 1'b1 : '0;
      if (state != ERROR && state_next == ERROR) calib_timeout <= 1'b1;
      wr_cnt <= wr_cnt + CntWidth'(aw_hs) - CntWidth'(b_hs);
      rd_cnt <= rd_cnt + CntWidth'(ar_hs) - CntWidth'(r_last_hs);
      wp_cnt <= wp_cnt + CntWidth'(aw_hs) - CntWidth'(w_last_hs);
    end
  end

  assign state_o         = state;
  assign isolated_o      = (state == ISOLATED);
  assign calib_timeout_o = calib_timeout;

endmodule

// File: tb/tb_dram_axi_calib_gate.sv
// Randomized bench for dram_axi_calib_gate against a queue-based model of bursts in flight.
`timescale 1ns/1ps
module tb_dram_axi_calib_gate;
  import dram_gate_pkg::*;

  localparam int unsigned MaxT          = 2;
  localparam int unsigned TimeoutCycles = 120;

  logic           clk = 1'b0;
  logic           rst, calib, iso, isolated, tout;
  logic [2:0]     state;
  dram_axi_req_t  slv_req, mst_req;
  dram_axi_resp_t slv_rsp, mst_rsp;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  dram_axi_calib_gate #(
    .MaxTxns      (MaxT),
    .CalibTimeout (TimeoutCycles)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .calib_done_i    (calib),
    .isolate_i       (iso),
    .isolated_o      (isolated),
    .state_o         (state),
    .calib_timeout_o (tout),
    .slv_req_i       (slv_req),
    .slv_rsp_o       (slv_rsp),
    .mst_req_o       (mst_req),
    .mst_rsp_i       (mst_rsp)
  );

  typedef struct {
    int id;
    int left;
  } rd_t;

  // Reference model: bursts in flight as queues, plus the gate state.
  dram_gate_state_e m_state;
  int  wait_cycles;
  bit  m_tout;
  int  aw_ids[$];
  int  b_q[$];
  rd_t r_q[$];
  int  cyc, first_ar, first_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_state     = WAIT_CALIB;
    wait_cycles = 0;
    m_tout      = 1'b0;
    aw_ids.delete();
    b_q.delete();
    r_q.delete();
    cyc       = 0;
    first_ar  = -1;
    first_err = -1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_upstream(input bit traffic);
    slv_req.aw_valid = traffic && ($urandom_range(0, 2) == 0);
    slv_req.aw_id    = 4'($urandom);
    slv_req.aw_addr  = $urandom;
    slv_req.aw_len   = 8'($urandom_range(0, 3));
    slv_req.w_valid  = traffic && ($urandom_range(0, 1) == 1);
    slv_req.w_last   = ($urandom_range(0, 2) == 0);
    slv_req.w_data   = $urandom;
    slv_req.w_strb   = '1;
    slv_req.b_ready  = ($urandom_range(0, 3) != 0);
    slv_req.ar_valid = traffic && ($urandom_range(0, 2) == 0);
    slv_req.ar_id    = 4'($urandom);
    slv_req.ar_addr  = $urandom;
    slv_req.ar_len   = 8'($urandom_range(0, 3));
    slv_req.r_ready  = ($urandom_range(0, 3) != 0);
  endtask

  task automatic check_blocked(input string tag);
    check({tag, "_state"}, state, WAIT_CALIB);
    check({tag, "_isolated"}, isolated, 1'b0);
    check({tag, "_mst_valids"}, {mst_req.aw_valid, mst_req.ar_valid, mst_req.w_valid}, 3'b000);
    check({tag, "_mst_readys"}, {mst_req.b_ready, mst_req.r_ready}, 2'b00);
    check({tag, "_slv_readys"}, {slv_rsp.aw_ready, slv_rsp.ar_ready, slv_rsp.w_ready}, 3'b000);
    check({tag, "_slv_valids"}, {slv_rsp.b_valid, slv_rsp.r_valid}, 2'b00);
  endtask

  // One clock cycle: memory-controller model drives, outputs are checked, model advances at the edge.
  task automatic tick();
    bit act, flow, aw_ok, ar_ok, w_ok, skip_up, drained;
    bit aw_hs, ar_hs, w_hs, b_hs, r_hs;
    int wr_out, wp_out, rd_out;
    wr_out = aw_ids.size() + b_q.size();
    wp_out = aw_ids.size();
    rd_out = r_q.size();
    mst_rsp.aw_ready = ($urandom_range(0, 3) != 0);
    mst_rsp.ar_ready = ($urandom_range(0, 3) != 0);
    mst_rsp.w_ready  = ($urandom_range(0, 3) != 0);
    mst_rsp.b_valid  = (b_q.size() > 0) && ($urandom_range(0, 2) != 0);
    mst_rsp.b_id     = (b_q.size() > 0) ? 4'(b_q[0]) : 4'd0;
    mst_rsp.b_resp   = RespOkay;
    mst_rsp.r_valid  = (r_q.size() > 0) && ($urandom_range(0, 2) != 0);
    mst_rsp.r_id     = (r_q.size() > 0) ? 4'(r_q[0].id) : 4'd0;
    mst_rsp.r_last   = (r_q.size() > 0) && (r_q[0].left == 1);
    mst_rsp.r_data   = $urandom;
    mst_rsp.r_resp   = RespOkay;
    #2;
    act   = (m_state == ACTIVE);
    flow  = act || (m_state == DRAIN);
    aw_ok = act && (wr_out < int'(MaxT));
    ar_ok = act && (rd_out < int'(MaxT));
    w_ok  = flow && (wp_out > 0);
`ifdef DRAM_GATE_ERR_RESP_EN
    skip_up = (m_state == ERROR);
`else
    skip_up = 1'b0;
`endif
    if (mst_req.ar_valid && first_ar < 0) first_ar = cyc;
    if (state == ERROR && first_err < 0) first_err = cyc;
    check("state", state, m_state);
    check("isolated", isolated, m_state == ISOLATED);
    check("calib_timeout", tout, m_tout);
    check("mst_aw_valid", mst_req.aw_valid, slv_req.aw_valid && aw_ok);
    check("mst_ar_valid", mst_req.ar_valid, slv_req.ar_valid && ar_ok);
    check("mst_w_valid", mst_req.w_valid, slv_req.w_valid && w_ok);
    check("mst_b_ready", mst_req.b_ready, slv_req.b_ready && flow);
    check("mst_r_ready", mst_req.r_ready, slv_req.r_ready && flow);
    if (!skip_up) begin
      check("slv_aw_ready", slv_rsp.aw_ready, mst_rsp.aw_ready && aw_ok);
      check("slv_ar_ready", slv_rsp.ar_ready, mst_rsp.ar_ready && ar_ok);
      check("slv_w_ready", slv_rsp.w_ready, mst_rsp.w_ready && w_ok);
      check("slv_b_valid", slv_rsp.b_valid, mst_rsp.b_valid && flow);
      check("slv_r_valid", slv_rsp.r_valid, mst_rsp.r_valid && flow);
    end
    if (slv_req.aw_valid && aw_ok) check("mst_aw_id", mst_req.aw_id, slv_req.aw_id);
    if (slv_req.ar_valid && ar_ok) check("mst_ar_id_len", {mst_req.ar_id, mst_req.ar_len},
                                         {slv_req.ar_id, slv_req.ar_len});
    if (mst_rsp.b_valid && flow) check("slv_b_id", slv_rsp.b_id, mst_rsp.b_id);
    if (mst_rsp.r_valid && flow) check("slv_r_beat", {slv_rsp.r_id, slv_rsp.r_data, slv_rsp.r_last},
                                       {mst_rsp.r_id, mst_rsp.r_data, mst_rsp.r_last});
    aw_hs   = slv_req.aw_valid && aw_ok && mst_rsp.aw_ready;
    ar_hs   = slv_req.ar_valid && ar_ok && mst_rsp.ar_ready;
    w_hs    = slv_req.w_valid && slv_req.w_last && w_ok && mst_rsp.w_ready;
    b_hs    = mst_rsp.b_valid && flow && slv_req.b_ready;
    r_hs    = mst_rsp.r_valid && flow && slv_req.r_ready;
    drained = (wr_out == 0) && (wp_out == 0) && (rd_out == 0);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (b_hs) void'(b_q.pop_front());
      if (w_hs) b_q.push_back(aw_ids.pop_front());
      if (aw_hs) aw_ids.push_back(int'(slv_req.aw_id));
      if (r_hs) begin
        r_q[0].left = r_q[0].left - 1;
        if (r_q[0].left == 0) void'(r_q.pop_front());
      end
      if (ar_hs) r_q.push_back('{id: int'(slv_req.ar_id), left: int'(slv_req.ar_len) + 1});
      case (m_state)
        WAIT_CALIB: begin
          if (iso) m_state = ISOLATED;
          else if (calib) m_state = ACTIVE;
          else if (wait_cycles == int'(TimeoutCycles) - 1) begin
            m_state = ERROR;
            m_tout  = 1'b1;
          end
          wait_cycles = (m_state == WAIT_CALIB) ? wait_cycles + 1 : 0;
        end
        ACTIVE:   if (iso || !calib) m_state = DRAIN;
        DRAIN:    if (drained) m_state = iso ? ISOLATED : (!calib ? WAIT_CALIB : ACTIVE);
        ISOLATED: if (!iso) m_state = WAIT_CALIB;
        ERROR:    if (calib) m_state = ACTIVE;
        default:  m_state = WAIT_CALIB;
      endcase
      cyc++;
    end
    #1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ar_taken, reset_done;
    int iso_left, calib_left;
    rst = 1'b1; calib = 1'b0; iso = 1'b0;
    slv_req = '0; mst_rsp = '0;
    model_reset();
    repeat (3) step();
    slv_req.aw_valid = 1'b1; slv_req.ar_valid = 1'b1; slv_req.w_valid = 1'b1;
    slv_req.b_ready  = 1'b1; slv_req.r_ready  = 1'b1;
    mst_rsp.aw_ready = 1'b1; mst_rsp.ar_ready = 1'b1; mst_rsp.w_ready = 1'b1;
    mst_rsp.b_valid  = 1'b1; mst_rsp.r_valid  = 1'b1;
    #1;
    check_blocked("reset");
    check("reset_timeout", tout, 1'b0);
    slv_req = '0;
    rst = 1'b0;

    // Calibration never completes: ERROR after TimeoutCycles cycles in WAIT_CALIB.
    for (int unsigned i = 0; i < TimeoutCycles + 4; i++) begin
      drive_upstream(i + 10 < TimeoutCycles);
      tick();
    end
    check("error_entry_cycle", first_err, TimeoutCycles);
    check("timeout_state", state, ERROR);
    check("timeout_flag", tout, 1'b1);

`ifdef DRAM_GATE_ERR_RESP_EN
    slv_req = '0; mst_rsp = '0;
    slv_req.ar_valid = 1'b1; slv_req.ar_id = 4'd5; slv_req.ar_len = 8'd1;
    #1;
    check("err_ar_ready", slv_rsp.ar_ready, 1'b1);
    step();
    slv_req.ar_valid = 1'b0; slv_req.r_ready = 1'b1;
    #1;
    check("err_r0", {slv_rsp.r_valid, slv_rsp.r_id, slv_rsp.r_resp, slv_rsp.r_last, slv_rsp.r_data},
          {1'b1, 4'd5, RespSlvErr, 1'b0, 32'd0});
    step();
    check("err_r1", {slv_rsp.r_valid, slv_rsp.r_id, slv_rsp.r_resp, slv_rsp.r_last},
          {1'b1, 4'd5, RespSlvErr, 1'b1});
    step();
    check("err_r_done", slv_rsp.r_valid, 1'b0);
    slv_req.aw_valid = 1'b1; slv_req.aw_id = 4'd3; slv_req.aw_len = 8'd0;
    #1;
    check("err_aw_ready", slv_rsp.aw_ready, 1'b1);
    step();
    slv_req.aw_valid = 1'b0; slv_req.w_valid = 1'b1; slv_req.w_last = 1'b1;
    #1;
    check("err_w_ready", slv_rsp.w_ready, 1'b1);
    check("err_no_early_b", slv_rsp.b_valid, 1'b0);
    step();
    slv_req.w_valid = 1'b0; slv_req.b_ready = 1'b1;
    #1;
    check("err_b", {slv_rsp.b_valid, slv_rsp.b_id, slv_rsp.b_resp}, {1'b1, 4'd3, RespSlvErr});
    step();
    check("err_b_done", slv_rsp.b_valid, 1'b0);
    check("err_state_held", state, ERROR);
    slv_req = '0;
`endif

    // Calibration arrives late: ERROR releases to ACTIVE, timeout flag stays sticky.
    calib = 1'b1;
    for (int unsigned i = 0; i < 40; i++) begin
      drive_upstream(i > 0);
      tick();
    end

    // Reset, then an AR waits from cycle 10 while calibration only lands at cycle 100.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    calib = 1'b0;
    ar_taken = 1'b0;
    for (int unsigned i = 0; i < 130; i++) begin
      slv_req = '0;
      slv_req.b_ready  = 1'b1;
      slv_req.r_ready  = 1'b1;
      slv_req.ar_valid = (i >= 10) && !ar_taken;
      slv_req.ar_id    = 4'd5;
      slv_req.ar_len   = 8'd2;
      calib = (i >= 100);
      tick();
      if (r_q.size() > 0) ar_taken = 1'b1;
    end
    check("first_ar_cycle", first_ar, 101);
    check("ar_forwarded", ar_taken, 1'b1);

    // Random traffic with isolate requests, calibration drops and one mid-burst reset.
    iso_left = 0; calib_left = 0; reset_done = 1'b0;
    for (int unsigned i = 0; i < 3000; i++) begin
      if (iso_left > 0) iso_left--;
      else if ($urandom_range(0, 149) == 0) iso_left = $urandom_range(5, 40);
      if (calib_left > 0) calib_left--;
      else if ($urandom_range(0, 199) == 0) calib_left = $urandom_range(5, 40);
      iso   = (iso_left > 0);
      calib = (calib_left == 0);
      drive_upstream(1'b1);
      if (i >= 1500 && !reset_done && aw_ids.size() > 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        reset_done = 1'b1;
        slv_req.aw_valid = 1'b1; slv_req.ar_valid = 1'b1; slv_req.w_valid = 1'b1;
        mst_rsp.b_valid  = 1'b1; mst_rsp.r_valid  = 1'b1;
        mst_rsp.aw_ready = 1'b1; mst_rsp.ar_ready = 1'b1; mst_rsp.w_ready = 1'b1;
        #1;
        check_blocked("mid_reset");
        drive_upstream(1'b1);
      end
      tick();
    end
    check("mid_reset_seen", reset_done, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
